// File: rtl/core_switch_pkg.sv
// Shared types and defaults for the redundant-core switch arbiter.
package core_switch_pkg;

  localparam int unsigned DEF_PERIOD         = 50000;
  localparam int unsigned DEF_DETECT_PERIODS = 3;
  localparam int unsigned DEF_GUARD_CYCLES   = 16;
  localparam int unsigned SWITCH_CNT_W       = 8;

  typedef enum logic [2:0] {
    CS_INIT,
    CS_OWN_A,
    CS_GUARD_TO_B,
    CS_OWN_B,
    CS_GUARD_TO_A
  } cs_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/heartbeat_filter.sv
// Debounces one heartbeat health flag: the output follows the input only after
// the input has disagreed with it for WINDOW consecutive clocks.
module heartbeat_filter
  import core_switch_pkg::*;
#(
  parameter int unsigned WINDOW   = DEF_DETECT_PERIODS * DEF_PERIOD,
  parameter bit          INIT_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  localparam int unsigned      CW   = cnt_width(WINDOW);
  localparam logic [CW-1:0]    LAST = CW'(WINDOW - 1);

  logic [CW-1:0] cnt_q;
  logic          filt_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= INIT_VAL;
    end else if (raw == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      filt_q <= raw;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/core_switch_arbiter.sv
// Chooses which redundant core owns the shared I/O, with break-before-make
// guard intervals. Define CORE_SWITCH_REVERT_EN for revertive (back-to-A) mode.
module core_switch_arbiter
  import core_switch_pkg::*;
#(
  parameter int unsigned PERIOD         = DEF_PERIOD,
  parameter int unsigned DETECT_PERIODS = DEF_DETECT_PERIODS,
  parameter int unsigned GUARD_CYCLES   = DEF_GUARD_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    healthy_a,
  input  logic                    healthy_b,
  input  logic                    force_req,
  input  logic                    force_sel,
  output logic                    sel_a,
  output logic                    sel_b,
  output logic                    switching,
  output logic                    fault,
  output logic [SWITCH_CNT_W-1:0] switch_count
);

  localparam int unsigned   WINDOW     = DETECT_PERIODS * PERIOD;
  localparam int unsigned   GW         = cnt_width(GUARD_CYCLES);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  logic filt_a, filt_b;

  heartbeat_filter #(.WINDOW(WINDOW), .INIT_VAL(1'b1)) u_filt_a (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (healthy_a),
    .filt (filt_a)
  );

  heartbeat_filter #(.WINDOW(WINDOW), .INIT_VAL(1'b1)) u_filt_b (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (healthy_b),
    .filt (filt_b)
  );

  cs_state_t               state_q;
  logic [GW-1:0]           guard_q;
  logic [SWITCH_CNT_W-1:0] count_q;
  logic                    sel_a_q, sel_b_q, switching_q, fault_q;
  logic                    force_to_a, force_to_b, go_a, go_b;

`ifdef CORE_SWITCH_REVERT_EN
  logic a_prev_q, rec_q, a_rise;
  assign a_rise = filt_a & ~a_prev_q;

  // Revert only after A has genuinely recovered through the filter, not when
  // B was forced in while A was still healthy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_prev_q <= 1'b1;
      rec_q    <= 1'b0;
    end else begin
      a_prev_q <= filt_a;
      if (state_q == CS_OWN_A && go_b) rec_q <= 1'b0;
      else if (a_rise)                 rec_q <= 1'b1;
    end
  end
`endif

  // NOTE: every always_comb output is assigned a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    force_to_a = force_req & ~force_sel;
    force_to_b = force_req & force_sel;
    go_b       = filt_b & (~filt_a | force_to_b);
    go_a       = filt_a & (~filt_b | force_to_a);
`ifdef CORE_SWITCH_REVERT_EN
    go_a       = go_a | (filt_a & (rec_q | a_rise) & ~force_to_b);
`endif
  end

  // Outputs are decoded from the registered state, so they lag it by a clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CS_INIT;
      guard_q     <= '0;
      count_q     <= '0;
      sel_a_q     <= 1'b0;
      sel_b_q     <= 1'b0;
      switching_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      sel_a_q     <= (state_q == CS_OWN_A);
      sel_b_q     <= (state_q == CS_OWN_B);
      switching_q <= (state_q == CS_GUARD_TO_A) || (state_q == CS_GUARD_TO_B);
      fault_q     <= ~filt_a & ~filt_b;

      case (state_q)
        CS_INIT: state_q <= (filt_a || !filt_b) ? CS_OWN_A : CS_OWN_B;
        CS_OWN_A: begin
          if (go_b) begin
            state_q <= CS_GUARD_TO_B;
            guard_q <= '0;
          end
        end
        CS_OWN_B: begin
          if (go_a) begin
            state_q <= CS_GUARD_TO_A;
            guard_q <= '0;
          end
        end
        CS_GUARD_TO_A, CS_GUARD_TO_B: begin
          if (guard_q == GUARD_LAST) begin
            state_q <= (state_q == CS_GUARD_TO_B) ? CS_OWN_B : CS_OWN_A;
            guard_q <= '0;
            if (count_q != '1) count_q <= count_q + 1'b1;
          end else begin
            guard_q <= guard_q + 1'b1;
          end
        end
        default: state_q <= CS_INIT;
      endcase
    end
  end

  assign sel_a        = sel_a_q;
  assign sel_b        = sel_b_q;
  assign switching    = switching_q;
  assign fault        = fault_q;
  assign switch_count = count_q;

endmodule
